// File: rtl/bram_axil_rd_resp_pkg.sv
// Shared definitions for the BRAM AXI4-Lite read-back slave.
// Contents: AXI response codes and the read/write FSM state encodings.
// Imported by bram_axil_rd_resp.
package bram_axil_rd_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Read path: accept address, pulse BRAM enable, wait out BRAM latency, hold response.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } rd_state_t;

  // Write path: collect AW and W beats in any order, then answer with SLVERR.
  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

endpackage

// File: rtl/bram_axil_rd_resp.sv
// AXI4-Lite slave giving the PS read-only access to the output BRAM through port B.
// Latency: AR handshake in cycle T -> S_RVALID first high in T+3; one read outstanding.
// Backpressure: S_ARREADY low until R handshake; S_RDATA/S_RRESP held while S_RREADY low.
// Ports: CLK/RST (sync, active-high); AR/R read channels; AW/W/B write channels
//   (always answered SLVERR, BRAM never written); EN_B/ADDR_B/DOUT_B to BRAM port B.
module bram_axil_rd_resp
  import bram_axil_rd_resp_pkg::*;
#(
  parameter int BW     = 32,
  parameter int AW     = 10,
  parameter int ENTRY  = 1024,
  parameter int AXI_AW = AW + 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [AXI_AW-1:0] S_ARADDR,
  input  logic              S_ARVALID,
  output logic              S_ARREADY,
  output logic [BW-1:0]     S_RDATA,
  output logic [1:0]        S_RRESP,
  output logic              S_RVALID,
  input  logic              S_RREADY,
  input  logic [AXI_AW-1:0] S_AWADDR,
  input  logic              S_AWVALID,
  output logic              S_AWREADY,
  input  logic [BW-1:0]     S_WDATA,
  input  logic [BW/8-1:0]   S_WSTRB,
  input  logic              S_WVALID,
  output logic              S_WREADY,
  output logic [1:0]        S_BRESP,
  output logic              S_BVALID,
  input  logic              S_BREADY,
  output logic              EN_B,
  output logic [AW-1:0]     ADDR_B,
  input  logic [BW-1:0]     DOUT_B
);

  // Sized copy of ENTRY so the range check works even when ENTRY == 2**AW.
  localparam logic [AW:0] LIMIT = (AW+1)'(ENTRY);

  // ---------------------------------------------------------------- read path
  rd_state_t     rd_state;
  rd_state_t     rd_next;
  logic [AW-1:0] word_addr;
  logic          oob;
  logic          ar_hs;
  logic          rd_err;

  assign word_addr = S_ARADDR[AXI_AW-1:2];
  assign oob       = {1'b0, word_addr} >= LIMIT;
  assign ar_hs     = S_ARVALID && S_ARREADY;

  always_ff @(posedge CLK) begin
    if (RST) rd_state <= IDLE;
    else     rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      IDLE:    if (ar_hs) rd_next = ISSUE;
      ISSUE:   rd_next = WAIT;
      WAIT:    rd_next = RESP;
      RESP:    if (S_RREADY) rd_next = IDLE;
      default: rd_next = IDLE;
    endcase
  end

  always_comb begin
    S_RVALID = (rd_state == RESP);
  end

  // Registered outputs: ARREADY tracks the next state so it is low during reset
  // and drops in the same edge that accepts an address. EN_B is set on the
  // accepting edge so it is high exactly for the ISSUE cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      S_ARREADY <= 1'b0;
      EN_B      <= 1'b0;
      ADDR_B    <= '0;
      rd_err    <= 1'b0;
      S_RDATA   <= '0;
      S_RRESP   <= RESP_OKAY;
    end else begin
      S_ARREADY <= (rd_next == IDLE);
      EN_B      <= (rd_state == IDLE) && ar_hs && !oob;
      if (rd_state == IDLE && ar_hs) begin
        ADDR_B <= word_addr;
        rd_err <= oob;
      end
      // DOUT_B carries the word addressed in ISSUE during WAIT.
      if (rd_state == WAIT) begin
        S_RDATA <= rd_err ? '0 : DOUT_B;
        S_RRESP <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // --------------------------------------------------------------- write path
  wr_state_t wr_state;
  wr_state_t wr_next;
  logic      aw_taken;
  logic      w_taken;
  logic      aw_done;
  logic      w_done;
  logic      aw_taken_nx;
  logic      w_taken_nx;

  // A beat counts as taken if it was latched earlier or handshakes this cycle.
  assign aw_done = aw_taken || (S_AWVALID && S_AWREADY);
  assign w_done  = w_taken  || (S_WVALID  && S_WREADY);

  always_ff @(posedge CLK) begin
    if (RST) wr_state <= W_IDLE;
    else     wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_done && w_done) wr_next = W_RESP;
      W_RESP:  if (S_BREADY) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    S_BVALID    = (wr_state == W_RESP);
    S_BRESP     = S_BVALID ? RESP_SLVERR : RESP_OKAY;
    // Flags only survive while still collecting beats; they clear on entry to W_RESP.
    aw_taken_nx = (wr_state == W_IDLE) && (wr_next == W_IDLE) && aw_done;
    w_taken_nx  = (wr_state == W_IDLE) && (wr_next == W_IDLE) && w_done;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      aw_taken  <= 1'b0;
      w_taken   <= 1'b0;
      S_AWREADY <= 1'b0;
      S_WREADY  <= 1'b0;
    end else begin
      aw_taken  <= aw_taken_nx;
      w_taken   <= w_taken_nx;
      S_AWREADY <= (wr_next == W_IDLE) && !aw_taken_nx;
      S_WREADY  <= (wr_next == W_IDLE) && !w_taken_nx;
    end
  end

  // Write payload and the byte offset of read addresses carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AWADDR, S_WDATA, S_WSTRB, S_ARADDR[1:0]};

endmodule

// File: tb/tb_bram_axil_rd_resp.sv
module tb_bram_axil_rd_resp;

  localparam int BW     = 32;
  localparam int AW     = 11;
  localparam int ENTRY  = 1024;
  localparam int AXI_AW = AW + 2;

  logic              CLK;
  logic              RST;
  logic [AXI_AW-1:0] S_ARADDR;
  logic              S_ARVALID;
  logic              S_ARREADY;
  logic [BW-1:0]     S_RDATA;
  logic [1:0]        S_RRESP;
  logic              S_RVALID;
  logic              S_RREADY;
  logic [AXI_AW-1:0] S_AWADDR;
  logic              S_AWVALID;
  logic              S_AWREADY;
  logic [BW-1:0]     S_WDATA;
  logic [BW/8-1:0]   S_WSTRB;
  logic              S_WVALID;
  logic              S_WREADY;
  logic [1:0]        S_BRESP;
  logic              S_BVALID;
  logic              S_BREADY;
  logic              EN_B;
  logic [AW-1:0]     ADDR_B;
  logic [BW-1:0]     DOUT_B;

  int n_chk  = 0;
  int n_fail = 0;

  bram_axil_rd_resp #(.BW(BW), .AW(AW), .ENTRY(ENTRY), .AXI_AW(AXI_AW)) dut (
    .CLK(CLK), .RST(RST),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .EN_B(EN_B), .ADDR_B(ADDR_B), .DOUT_B(DOUT_B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // BRAM port B model: preloaded, one-cycle read latency, output held when disabled.
  logic [BW-1:0] ram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'hA000_0000 + 32'(i);
    DOUT_B = 32'hDEAD_BEEF;
  end
  always @(posedge CLK) if (EN_B) DOUT_B <= ram[ADDR_B];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: what a read of byte address a must return.
  function automatic void ref_read(input logic [AXI_AW-1:0] a,
                                   output logic [31:0] d, output logic [1:0] r);
    int w;
    w = int'(a) / 4;
    if (w >= ENTRY) begin
      d = 32'h0;
      r = 2'b10;
    end else begin
      d = 32'hA000_0000 + 32'(w);
      r = 2'b00;
    end
  endfunction

  // One AXI read; hold = cycles RREADY stays low after RVALID rises.
  task automatic do_read(input logic [AXI_AW-1:0] a, input int hold);
    logic [31:0]   ed;
    logic [1:0]    er;
    int            n;
    int            en_cnt;
    logic [AW-1:0] en_a;
    ref_read(a, ed, er);
    en_cnt = 0;
    en_a   = '0;
    S_ARADDR  = a;
    S_ARVALID = 1'b1;
    S_RREADY  = (hold == 0);
    n = 0;
    while (!S_ARREADY && n < 50) begin @(negedge CLK); n++; end
    if (!S_ARREADY) begin
      chk("ar_wait_timeout", 32'd0, 32'd1);
      S_ARVALID = 1'b0;
      return;
    end
    @(negedge CLK);
    S_ARVALID = 1'b0;
    S_ARADDR  = AXI_AW'($urandom);
    for (int k = 1; k <= 3; k++) begin
      if (EN_B) begin en_cnt++; en_a = ADDR_B; end
      chk("arready_busy", S_ARREADY, 0);
      if (k < 3) begin
        chk("rvalid_early", S_RVALID, 0);
        @(negedge CLK);
      end
    end
    chk("rvalid_t3", S_RVALID, 1);
    chk("rdata", S_RDATA, ed);
    chk("rresp", S_RRESP, er);
    for (int j = 0; j < hold; j++) begin
      @(negedge CLK);
      if (EN_B) en_cnt++;
      chk("rvalid_hold", S_RVALID, 1);
      chk("rdata_hold", S_RDATA, ed);
      chk("rresp_hold", S_RRESP, er);
      chk("arready_hold", S_ARREADY, 0);
    end
    S_RREADY = 1'b1;
    @(negedge CLK);
    chk("rvalid_clear", S_RVALID, 0);
    chk("arready_back", S_ARREADY, 1);
    chk("en_b_pulses", en_cnt, (er == 2'b00) ? 1 : 0);
    if (en_cnt == 1) chk("addr_b", en_a, 32'(a >> 2));
  endtask

  // One rejected write; gap = cycles between AW handshake and W valid (0: same cycle).
  task automatic do_write(input int gap);
    int n;
    S_AWADDR  = AXI_AW'($urandom);
    S_WDATA   = $urandom;
    S_WSTRB   = '1;
    S_BREADY  = 1'b1;
    S_AWVALID = 1'b1;
    S_WVALID  = (gap == 0);
    n = 0;
    while (!(S_AWREADY && (gap > 0 || S_WREADY)) && n < 50) begin @(negedge CLK); n++; end
    if (n >= 50) begin
      chk("aw_wait_timeout", 32'd0, 32'd1);
      S_AWVALID = 1'b0;
      S_WVALID  = 1'b0;
      return;
    end
    @(negedge CLK);
    S_AWVALID = 1'b0;
    if (gap > 0) begin
      for (int j = 0; j < gap; j++) begin
        chk("awready_drop", S_AWREADY, 0);
        chk("bvalid_early", S_BVALID, 0);
        if (j < gap - 1) @(negedge CLK);
      end
      chk("wready_open", S_WREADY, 1);
      S_WVALID = 1'b1;
      @(negedge CLK);
    end
    S_WVALID = 1'b0;
    chk("bvalid", S_BVALID, 1);
    chk("bresp", S_BRESP, 2'b10);
    @(negedge CLK);
    chk("bvalid_clear", S_BVALID, 0);
    chk("awready_back", S_AWREADY, 1);
    chk("wready_back", S_WREADY, 1);
  endtask

  int n;
  int rv;
  int en_seen;

  initial begin
    RST = 1'b1;
    S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0;
    S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = '0;
    S_WVALID = 1'b0; S_BREADY = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_arready", S_ARREADY, 0);
    chk("rst_rvalid", S_RVALID, 0);
    chk("rst_rdata", S_RDATA, 0);
    chk("rst_rresp", S_RRESP, 0);
    chk("rst_awready", S_AWREADY, 0);
    chk("rst_wready", S_WREADY, 0);
    chk("rst_bvalid", S_BVALID, 0);
    chk("rst_bresp", S_BRESP, 0);
    chk("rst_en_b", EN_B, 0);
    chk("rst_addr_b", ADDR_B, 0);
    RST = 1'b0;
    @(negedge CLK);

    do_read(13'h010, 0);
    do_read(13'h013, 0);
    do_read(13'h0FFC, 0);
    do_read(13'h010, 5);
    do_read(13'h1000, 0);
    do_read(13'h1FFF, 2);
    do_write(3);
    do_write(0);
    do_read(13'h010, 0);

    // Reset during WAIT must drop the pending read without a response.
    S_RREADY  = 1'b1;
    S_ARADDR  = 13'h020;
    S_ARVALID = 1'b1;
    n = 0;
    while (!S_ARREADY && n < 50) begin @(negedge CLK); n++; end
    chk("abort_ar_ready", S_ARREADY, 1);
    @(negedge CLK);
    S_ARVALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_rvalid_rst", S_RVALID, 0);
    chk("abort_en_b_rst", EN_B, 0);
    RST = 1'b0;
    rv = 0;
    en_seen = 0;
    repeat (5) begin
      @(negedge CLK);
      if (S_RVALID) rv++;
      if (EN_B) en_seen++;
    end
    chk("abort_no_rvalid", rv, 0);
    chk("abort_no_en_b", en_seen, 0);
    do_read(13'h008, 0);

    // Read and write channels run side by side.
    fork
      do_read(13'h100, 2);
      do_write(0);
    join
    fork
      do_read(13'h1004, 1);
      do_write(2);
    join

    for (int i = 0; i < 40; i++) begin
      logic [AXI_AW-1:0] a;
      a = AXI_AW'($urandom_range(0, (1 << AXI_AW) - 1));
      if (i % 4 == 0) a = AXI_AW'($urandom_range(0, 3)) + 13'h0FFC + AXI_AW'(4 * (i % 8 == 0));
      do_read(a, int'($urandom_range(0, 3)));
      if (i % 10 == 5) do_write(int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
